// File: rtl/lsu_mem_stage.sv
// lsu_mem_stage: memory-access stage between EX/MEM and MEM/WB.
//   Takes a load or store from the EX/MEM register and runs it over a data
//   memory port that allows one request at a time (req/ack). It builds byte
//   enables and lane-replicated store data, and sign/zero-extends load data.
//   It presents registered writeback outputs to MEM/WB, stalls upstream while
//   an access is in flight, and pulses a fault for illegal, misaligned or
//   timed-out accesses.
// Ports:
//   i_clk, i_reset            clock, synchronous active-low reset
//   i_pc .. i_funct3          EX/MEM instruction fields and control
//   o_stall                   combinational stall to EX/MEM and upstream
//   o_mem_* / i_mem_*         data-memory request (registered) and response
//   o_wb_*                    registered writeback to MEM/WB
//   o_fault, o_fault_pc       one-cycle fault pulse with the faulting PC
module lsu_mem_stage #(
    parameter int ACK_TIMEOUT = 64  // BUSY cycles without ack before fault; 0 = never
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_alu_result,
    input  logic [31:0] i_store_data,
    input  logic [4:0]  i_rd,
    input  logic        i_valid,
    input  logic        i_bubble,
    input  logic        i_mem_read,
    input  logic        i_mem_write,
    input  logic        i_wb_en,
    input  logic [2:0]  i_funct3,
    output logic        o_stall,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [3:0]  o_mem_be,
    output logic [31:0] o_mem_wdata,
    input  logic        i_mem_ack,
    input  logic [31:0] i_mem_rdata,
    output logic        o_wb_valid,
    output logic        o_wb_en,
    output logic [4:0]  o_wb_rd,
    output logic [31:0] o_wb_data,
    output logic        o_fault,
    output logic [31:0] o_fault_pc
);

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    localparam int CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        f3_q, f3_d;
    logic [1:0]        lo_q, lo_d;
    logic [4:0]        rd_q, rd_d;
    logic              wb_en_lat_q, wb_en_lat_d;
    logic              is_load_q, is_load_d;
    logic [31:0]       pc_q, pc_d;

    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [31:0]       mem_addr_q, mem_addr_d;
    logic [3:0]        mem_be_q, mem_be_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              wb_valid_q, wb_valid_d;
    logic              wb_en_q, wb_en_d;
    logic [4:0]        wb_rd_q, wb_rd_d;
    logic [31:0]       wb_data_q, wb_data_d;
    logic              fault_q, fault_d;
    logic [31:0]       fault_pc_q, fault_pc_d;

    // Input decode
    logic        live, mem_op, legal, misal, go, bad_op, timeout_hit;
    logic [3:0]  st_be;
    logic [31:0] st_wdata, ld_data;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        live   = i_valid & ~i_bubble;
        mem_op = live & (i_mem_read | i_mem_write);
        // Read wins when both read and write are asserted.
        if (i_mem_read)
            legal = i_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        else
            legal = i_funct3 inside {3'b000, 3'b001, 3'b010};
        misal  = ((i_funct3[1:0] == 2'b01) & i_alu_result[0]) |
                 ((i_funct3[1:0] == 2'b10) & (i_alu_result[1:0] != 2'b00));
        go     = mem_op & legal & ~misal;
        bad_op = mem_op & ~(legal & ~misal);
        timeout_hit = (ACK_TIMEOUT > 0) && (cnt_q == CNT_LAST);
    end

    // Store lane formatting
    always_comb begin
        st_be    = 4'b1111;
        st_wdata = i_store_data;
        case (i_funct3[1:0])
            2'b00: begin
                st_be    = 4'b0001 << i_alu_result[1:0];
                st_wdata = {4{i_store_data[7:0]}};
            end
            2'b01: begin
                st_be    = 4'b0011 << {i_alu_result[1], 1'b0};
                st_wdata = {2{i_store_data[15:0]}};
            end
            default: begin
                st_be    = 4'b1111;
                st_wdata = i_store_data;
            end
        endcase
    end

    // Load lane extraction from the latched size and address offset
    always_comb begin
        case (lo_q)
            2'd0:    ld_byte = i_mem_rdata[7:0];
            2'd1:    ld_byte = i_mem_rdata[15:8];
            2'd2:    ld_byte = i_mem_rdata[23:16];
            default: ld_byte = i_mem_rdata[31:24];
        endcase
        ld_half = lo_q[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];
        case (f3_q)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_data = {24'b0, ld_byte};
            3'b101:  ld_data = {16'b0, ld_half};
            default: ld_data = i_mem_rdata;
        endcase
    end

    // Next-state and outputs
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        f3_d        = f3_q;
        lo_d        = lo_q;
        rd_d        = rd_q;
        wb_en_lat_d = wb_en_lat_q;
        is_load_d   = is_load_q;
        pc_d        = pc_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        wb_valid_d  = wb_valid_q;
        wb_en_d     = wb_en_q;
        wb_rd_d     = wb_rd_q;
        wb_data_d   = wb_data_q;
        fault_d     = 1'b0;
        fault_pc_d  = fault_pc_q;
        o_stall     = 1'b0;

        case (state_q)
            S_IDLE: begin
                o_stall = go;
                if (go) begin
                    state_d     = S_BUSY;
                    cnt_d       = '0;
                    f3_d        = i_funct3;
                    lo_d        = i_alu_result[1:0];
                    rd_d        = i_rd;
                    wb_en_lat_d = i_wb_en;
                    is_load_d   = i_mem_read;
                    pc_d        = i_pc;
                    mem_req_d   = 1'b1;
                    mem_we_d    = ~i_mem_read;
                    mem_addr_d  = {i_alu_result[31:2], 2'b00};
                    mem_be_d    = i_mem_read ? 4'b1111 : st_be;
                    mem_wdata_d = i_mem_read ? 32'h0 : st_wdata;
                    wb_valid_d  = 1'b0;
                end else if (bad_op) begin
                    fault_d    = 1'b1;
                    fault_pc_d = i_pc;
                    wb_valid_d = 1'b0;
                    wb_en_d    = 1'b0;
                    wb_rd_d    = '0;
                    wb_data_d  = '0;
                end else if (live) begin
                    wb_valid_d = 1'b1;
                    wb_en_d    = i_wb_en;
                    wb_rd_d    = i_rd;
                    wb_data_d  = i_alu_result;
                end else begin
                    wb_valid_d = 1'b0;
                    wb_en_d    = 1'b0;
                    wb_rd_d    = '0;
                    wb_data_d  = '0;
                end
            end
            S_BUSY: begin
                // EX/MEM may advance on the ack edge itself.
                o_stall = ~i_mem_ack;
                if (i_mem_ack) begin
                    state_d    = S_IDLE;
                    mem_req_d  = 1'b0;
                    wb_valid_d = 1'b1;
                    wb_rd_d    = rd_q;
                    wb_en_d    = is_load_q & wb_en_lat_q;
                    wb_data_d  = is_load_q ? ld_data : 32'h0;
                end else if (timeout_hit) begin
                    state_d    = S_IDLE;
                    mem_req_d  = 1'b0;
                    fault_d    = 1'b1;
                    fault_pc_d = pc_q;
                    wb_valid_d = 1'b0;
                    wb_en_d    = 1'b0;
                    wb_rd_d    = '0;
                    wb_data_d  = '0;
                end else if (ACK_TIMEOUT > 0) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            f3_q        <= '0;
            lo_q        <= '0;
            rd_q        <= '0;
            wb_en_lat_q <= 1'b0;
            is_load_q   <= 1'b0;
            pc_q        <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
            wb_valid_q  <= 1'b0;
            wb_en_q     <= 1'b0;
            wb_rd_q     <= '0;
            wb_data_q   <= '0;
            fault_q     <= 1'b0;
            fault_pc_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            f3_q        <= f3_d;
            lo_q        <= lo_d;
            rd_q        <= rd_d;
            wb_en_lat_q <= wb_en_lat_d;
            is_load_q   <= is_load_d;
            pc_q        <= pc_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
            wb_valid_q  <= wb_valid_d;
            wb_en_q     <= wb_en_d;
            wb_rd_q     <= wb_rd_d;
            wb_data_q   <= wb_data_d;
            fault_q     <= fault_d;
            fault_pc_q  <= fault_pc_d;
        end
    end

    assign o_mem_req   = mem_req_q;
    assign o_mem_we    = mem_we_q;
    assign o_mem_addr  = mem_addr_q;
    assign o_mem_be    = mem_be_q;
    assign o_mem_wdata = mem_wdata_q;
    assign o_wb_valid  = wb_valid_q;
    assign o_wb_en     = wb_en_q;
    assign o_wb_rd     = wb_rd_q;
    assign o_wb_data   = wb_data_q;
    assign o_fault     = fault_q;
    assign o_fault_pc  = fault_pc_q;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Bench for lsu_mem_stage: table of instructions with hand-computed expected
// bus/writeback values, a scoreboard queue of expected retire/fault events
// checked by a monitor, and hand sequences for reset-in-BUSY and stray acks.
module tb_lsu_mem_stage;

    localparam int TO = 4;
    localparam int K_NONE = 0, K_WB = 1, K_FAULT = 2;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b0;
    logic [31:0] i_pc = '0, i_alu_result = '0, i_store_data = '0;
    logic [4:0]  i_rd = '0;
    logic        i_valid = 1'b0, i_bubble = 1'b0, i_mem_read = 1'b0, i_mem_write = 1'b0;
    logic        i_wb_en = 1'b0;
    logic [2:0]  i_funct3 = '0;
    logic        o_stall, o_mem_req, o_mem_we;
    logic [31:0] o_mem_addr, o_mem_wdata;
    logic [3:0]  o_mem_be;
    logic        i_mem_ack = 1'b0;
    logic [31:0] i_mem_rdata = '0;
    logic        o_wb_valid, o_wb_en, o_fault;
    logic [4:0]  o_wb_rd;
    logic [31:0] o_wb_data, o_fault_pc;

    always #5 i_clk = ~i_clk;

    lsu_mem_stage #(.ACK_TIMEOUT(TO)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_pc(i_pc), .i_alu_result(i_alu_result),
        .i_store_data(i_store_data), .i_rd(i_rd), .i_valid(i_valid), .i_bubble(i_bubble),
        .i_mem_read(i_mem_read), .i_mem_write(i_mem_write), .i_wb_en(i_wb_en),
        .i_funct3(i_funct3), .o_stall(o_stall), .o_mem_req(o_mem_req), .o_mem_we(o_mem_we),
        .o_mem_addr(o_mem_addr), .o_mem_be(o_mem_be), .o_mem_wdata(o_mem_wdata),
        .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata), .o_wb_valid(o_wb_valid),
        .o_wb_en(o_wb_en), .o_wb_rd(o_wb_rd), .o_wb_data(o_wb_data), .o_fault(o_fault),
        .o_fault_pc(o_fault_pc)
    );

    typedef struct {
        logic        rd_op, wr_op, bub, wbe;
        logic [2:0]  f3;
        logic [31:0] addr, sdata, rdata, pc;
        logic [4:0]  rd;
        int          dly;      // BUSY cycles before ack; >= TO means never
        logic        ereq, ewe;
        logic [3:0]  ebe;
        logic [31:0] ewd;
        int          kind;
        logic        ewbe;
        logic [31:0] edata;    // wb data, or fault PC
    } vec_t;

    typedef struct {
        logic        fault;
        logic        wb_en;
        logic        chk_rd;
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Retire/fault monitor against the scoreboard
    always @(negedge i_clk) begin
        if (o_wb_valid || o_fault) begin
            exp_t e;
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_out wb_valid=%b fault=%b data=%h t=%0t",
                         o_wb_valid, o_fault, o_wb_data, $time);
            end else begin
                e = sb.pop_front();
                if (e.fault) begin
                    if (!(o_fault && !o_wb_valid && o_fault_pc == e.data)) begin
                        bad++;
                        $display("FAIL fault_evt act fault=%b wbv=%b pc=%h exp pc=%h",
                                 o_fault, o_wb_valid, o_fault_pc, e.data);
                    end
                end else if (!(o_wb_valid && !o_fault && o_wb_en == e.wb_en &&
                               o_wb_data == e.data && (!e.chk_rd || o_wb_rd == e.rd))) begin
                    bad++;
                    $display("FAIL wb_evt act v=%b f=%b en=%b rd=%0d d=%h exp en=%b rd=%0d d=%h",
                             o_wb_valid, o_fault, o_wb_en, o_wb_rd, o_wb_data,
                             e.wb_en, e.rd, e.data);
                end
            end
        end
    end

    function automatic vec_t mk(input logic rd_op, input logic wr_op, input logic bub,
                                input logic wbe, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] sdata, input logic [31:0] rdata,
                                input logic [31:0] pc, input logic [4:0] rd, input int dly,
                                input logic ereq, input logic ewe, input logic [3:0] ebe,
                                input logic [31:0] ewd, input int kind, input logic ewbe,
                                input logic [31:0] edata);
        vec_t v;
        v.rd_op = rd_op; v.wr_op = wr_op; v.bub = bub; v.wbe = wbe; v.f3 = f3;
        v.addr = addr; v.sdata = sdata; v.rdata = rdata; v.pc = pc; v.rd = rd;
        v.dly = dly; v.ereq = ereq; v.ewe = ewe; v.ebe = ebe; v.ewd = ewd;
        v.kind = kind; v.ewbe = ewbe; v.edata = edata;
        return v;
    endfunction

    // Called just after a rising edge; returns just after a rising edge.
    task automatic run_op(input vec_t v, input int idx);
        exp_t e;
        logic ack;
        logic [31:0] eaddr;
        eaddr = {v.addr[31:2], 2'b00};
        i_valid = 1'b1; i_bubble = v.bub; i_mem_read = v.rd_op; i_mem_write = v.wr_op;
        i_wb_en = v.wbe; i_funct3 = v.f3; i_alu_result = v.addr; i_store_data = v.sdata;
        i_pc = v.pc; i_rd = v.rd; i_mem_ack = 1'b0;
        @(negedge i_clk);
        chk($sformatf("v%0d stall_issue", idx), {31'b0, o_stall}, {31'b0, v.ereq});
        if (v.kind != K_NONE) begin
            e.fault  = (v.kind == K_FAULT);
            e.wb_en  = v.ewbe;
            e.chk_rd = !(v.wr_op && !v.rd_op);
            e.rd     = v.rd;
            e.data   = v.edata;
            sb.push_back(e);
        end
        @(posedge i_clk); #1;
        i_valid = 1'b0; i_mem_read = 1'b0; i_mem_write = 1'b0; i_bubble = 1'b0;
        if (v.ereq) begin
            for (int k = 0; k < 2 * TO; k++) begin
                ack = (k == v.dly);
                i_mem_ack = ack;
                i_mem_rdata = ack ? v.rdata : 32'h0BAD_0BAD;
                @(negedge i_clk);
                chk($sformatf("v%0d stall_busy%0d", idx, k), {31'b0, o_stall}, {31'b0, !ack});
                chk($sformatf("v%0d req_hold%0d", idx, k),
                    {o_mem_req, o_mem_we, o_mem_be} == {1'b1, v.ewe, v.ebe} &&
                    o_mem_addr == eaddr && o_mem_wdata == v.ewd ? 32'd1 : 32'd0, 32'd1);
                @(posedge i_clk); #1;
                i_mem_ack = 1'b0;
                if (ack || k == TO - 1) break;
            end
            chk($sformatf("v%0d req_drop", idx), {31'b0, o_mem_req}, 32'd0);
        end else begin
            chk($sformatf("v%0d no_req", idx), {31'b0, o_mem_req}, 32'd0);
            if (v.kind == K_NONE)
                chk($sformatf("v%0d no_out", idx), {30'b0, o_wb_valid, o_fault}, 32'd0);
        end
    endtask

    vec_t vecs[$];

    initial begin
        //               rd wr bub wbe f3      addr          sdata         rdata         pc     rd  dly req we be     wdata         kind     wbe edata
        vecs.push_back(mk(1, 0, 0, 1, 3'b000, 32'h103,      32'h0,        32'h80FF_FF7F, 32'h10, 5,  1, 1, 0, 4'hF, 32'h0,        K_WB,    1, 32'hFFFF_FF80));
        vecs.push_back(mk(0, 1, 0, 1, 3'b001, 32'h202,      32'h1234_ABCD, 32'h0,        32'h14, 7,  0, 1, 1, 4'hC, 32'hABCD_ABCD, K_WB,    0, 32'h0));
        vecs.push_back(mk(1, 0, 0, 1, 3'b101, 32'h0,        32'h0,        32'h0000_8001, 32'h18, 9,  3, 1, 0, 4'hF, 32'h0,        K_WB,    1, 32'h0000_8001));
        vecs.push_back(mk(1, 0, 0, 1, 3'b010, 32'h102,      32'h0,        32'h0,        32'h40, 1,  0, 0, 0, 4'h0, 32'h0,        K_FAULT, 0, 32'h40));
        vecs.push_back(mk(1, 0, 0, 1, 3'b010, 32'h300,      32'h0,        32'h0,        32'h80, 2, 99, 1, 0, 4'hF, 32'h0,        K_FAULT, 0, 32'h80));
        vecs.push_back(mk(0, 0, 0, 1, 3'b000, 32'hDEAD_BEEF, 32'h0,       32'h0,        32'h84, 3,  0, 0, 0, 4'h0, 32'h0,        K_WB,    1, 32'hDEAD_BEEF));
        vecs.push_back(mk(1, 0, 0, 1, 3'b001, 32'h2,        32'h0,        32'h8001_7FFF, 32'h88, 4,  0, 1, 0, 4'hF, 32'h0,        K_WB,    1, 32'hFFFF_8001));
        vecs.push_back(mk(1, 0, 0, 1, 3'b100, 32'h1,        32'h0,        32'h0000_9A00, 32'h8C, 6,  2, 1, 0, 4'hF, 32'h0,        K_WB,    1, 32'h0000_009A));
        vecs.push_back(mk(0, 1, 0, 1, 3'b000, 32'h3,        32'h0000_0055, 32'h0,        32'h90, 8,  0, 1, 1, 4'h8, 32'h5555_5555, K_WB,    0, 32'h0));
        vecs.push_back(mk(0, 1, 0, 0, 3'b010, 32'h0,        32'hCAFE_F00D, 32'h0,        32'h94, 10, 1, 1, 1, 4'hF, 32'hCAFE_F00D, K_WB,    0, 32'h0));
        vecs.push_back(mk(1, 0, 0, 1, 3'b011, 32'h0,        32'h0,        32'h0,        32'h44, 1,  0, 0, 0, 4'h0, 32'h0,        K_FAULT, 0, 32'h44));
        vecs.push_back(mk(0, 1, 0, 0, 3'b100, 32'h0,        32'h11,       32'h0,        32'h48, 0,  0, 0, 0, 4'h0, 32'h0,        K_FAULT, 0, 32'h48));
        vecs.push_back(mk(1, 0, 0, 1, 3'b001, 32'h101,      32'h0,        32'h0,        32'h4C, 1,  0, 0, 0, 4'h0, 32'h0,        K_FAULT, 0, 32'h4C));
        vecs.push_back(mk(1, 1, 0, 1, 3'b010, 32'h8,        32'hFFFF_FFFF, 32'h1122_3344, 32'h98, 11, 0, 1, 0, 4'hF, 32'h0,        K_WB,    1, 32'h1122_3344));
        vecs.push_back(mk(0, 0, 0, 0, 3'b000, 32'h5555_AAAA, 32'h0,       32'h0,        32'h9C, 12, 0, 0, 0, 4'h0, 32'h0,        K_WB,    0, 32'h5555_AAAA));
        vecs.push_back(mk(1, 0, 1, 1, 3'b010, 32'h0,        32'h0,        32'h0,        32'hA0, 13, 0, 0, 0, 4'h0, 32'h0,        K_NONE,  0, 32'h0));
        vecs.push_back(mk(1, 0, 0, 1, 3'b000, 32'h1,        32'h0,        32'h0000_7F00, 32'hA4, 13, 0, 1, 0, 4'hF, 32'h0,        K_WB,    1, 32'h0000_007F));
        vecs.push_back(mk(0, 1, 0, 1, 3'b001, 32'h200,      32'h0000_BEEF, 32'h0,        32'hA8, 14, 0, 1, 1, 4'h3, 32'hBEEF_BEEF, K_WB,    0, 32'h0));

        // Reset state
        repeat (3) @(posedge i_clk);
        #1;
        chk("rst_outs", {o_mem_req, o_mem_we, o_mem_be, o_wb_valid, o_wb_en, o_wb_rd, o_fault, o_stall},
            32'h0);
        chk("rst_data", o_wb_data | o_mem_addr | o_mem_wdata | o_fault_pc, 32'h0);
        i_reset = 1'b1;
        @(posedge i_clk); #1;

        foreach (vecs[i]) run_op(vecs[i], i);

        // Stray ack while idle: no output, no stall
        i_mem_ack = 1'b1; i_mem_rdata = 32'hFFFF_FFFF;
        @(negedge i_clk);
        chk("stray_ack_stall", {31'b0, o_stall}, 32'd0);
        @(posedge i_clk); #1;
        i_mem_ack = 1'b0;
        chk("stray_ack_out", {30'b0, o_wb_valid, o_mem_req}, 32'd0);

        // Reset in the second BUSY cycle discards the access
        i_valid = 1'b1; i_mem_read = 1'b1; i_funct3 = 3'b010; i_alu_result = 32'h10;
        i_pc = 32'hB0; i_rd = 5'd15; i_wb_en = 1'b1;
        @(negedge i_clk);
        chk("rb_stall_issue", {31'b0, o_stall}, 32'd1);
        @(posedge i_clk); #1;
        i_valid = 1'b0; i_mem_read = 1'b0;
        @(negedge i_clk);
        chk("rb_req_busy1", {31'b0, o_mem_req}, 32'd1);
        @(posedge i_clk); #1;
        i_reset = 1'b0;
        @(posedge i_clk); #1;
        i_reset = 1'b1;
        chk("rb_outs", {o_mem_req, o_mem_we, o_mem_be, o_wb_valid, o_wb_en, o_wb_rd, o_fault, o_stall},
            32'h0);
        chk("rb_data", o_wb_data | o_mem_addr | o_mem_wdata | o_fault_pc, 32'h0);
        i_mem_ack = 1'b1; i_mem_rdata = 32'h1234_5678;
        @(negedge i_clk);
        chk("rb_late_ack_stall", {31'b0, o_stall}, 32'd0);
        @(posedge i_clk); #1;
        i_mem_ack = 1'b0;
        chk("rb_late_ack_out", {29'b0, o_wb_valid, o_fault, o_mem_req}, 32'd0);

        // Normal operation after reset
        run_op(mk(0, 0, 0, 1, 3'b000, 32'h0BEE_F000, 32'h0, 32'h0, 32'hC0, 20, 0,
                  0, 0, 4'h0, 32'h0, K_WB, 1, 32'h0BEE_F000), 100);
        run_op(mk(1, 0, 0, 1, 3'b010, 32'h40, 32'h0, 32'hA5A5_5A5A, 32'hC4, 21, 0,
                  1, 0, 4'hF, 32'h0, K_WB, 1, 32'hA5A5_5A5A), 101);

        repeat (3) @(posedge i_clk);
        #1;
        chk("sb_drained", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/lsu_mem_stage.md
Name: lsu_mem_stage

Overview:
Memory-access stage fed directly by the EX/MEM pipeline register. It performs loads and stores over a single-outstanding req/ack data-memory port and generates byte enables and lane-replicated store data. It sign/zero-extends load data and produces registered writeback outputs for the MEM/WB register. It raises a pipeline stall while a memory access is in flight and flags misaligned, illegal or timed-out accesses.

Parameters:
ACK_TIMEOUT, 64, number of BUSY cycles without i_mem_ack before the access is abandoned as a fault; 0 disables the timeout.

Ports:
i_clk  in  1  clock
i_reset  in  1  synchronous active-low reset
i_pc  in  32  PC of instruction in EX/MEM
i_alu_result  in  32  ALU result; the effective address for memory ops
i_store_data  in  32  unaligned store operand (rs2)
i_rd  in  5  destination register
i_valid  in  1  EX/MEM ctrl_valid
i_bubble  in  1  EX/MEM ctrl_bubble
i_mem_read  in  1  load
i_mem_write  in  1  store
i_wb_en  in  1  register writeback enable
i_funct3  in  3  access size/sign
o_stall  out  1  combinational stall to EX/MEM and upstream stages
o_mem_req  out  1  memory request, registered
o_mem_we  out  1  1 = write
o_mem_addr  out  32  word-aligned address ({addr[31:2],2'b00})
o_mem_be  out  4  byte enables
o_mem_wdata  out  32  lane-replicated store data
i_mem_ack  in  1  one-cycle access completion
i_mem_rdata  in  32  read word, valid with i_mem_ack
o_wb_valid  out  1  instruction retired this cycle
o_wb_en  out  1  write rd
o_wb_rd  out  5  destination
o_wb_data  out  32  writeback value
o_fault  out  1  one-cycle fault pulse
o_fault_pc  out  32  PC of the faulting instruction

Behaviour:
- Reset (i_reset=0 at the clock edge): state=IDLE, timeout counter=0, every registered output=0. Reset during BUSY drops o_mem_req on that edge and discards the access with no writeback and no fault.
- An input is live when i_valid=1 and i_bubble=0. A live input is a memory op when i_mem_read or i_mem_write is set; if both are set, the read takes priority.
- Legal funct3: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW. Any other funct3 on a memory op is illegal.
- Misaligned: halfword access with addr[0]=1; word access with addr[1:0]!=0.
- IDLE, non-memory live op: next edge sets o_wb_valid=1, o_wb_en=i_wb_en, o_wb_rd=i_rd, o_wb_data=i_alu_result. No stall; latency 1 cycle.
- IDLE, non-live input: next edge sets o_wb_valid=0, o_wb_en=0, o_wb_rd=0, o_wb_data=0.
- IDLE, illegal or misaligned memory op: no request, no stall, no writeback. Next edge sets o_fault=1 and o_fault_pc=i_pc for one cycle.
- IDLE, legal aligned memory op:
  - o_stall=1 combinationally this cycle.
  - Next edge latches funct3, addr[1:0], rd and wb_en; sets o_mem_req=1 with o_mem_we, o_mem_addr, o_mem_be and o_mem_wdata; moves to BUSY; clears the counter.
  - The same edge clears o_wb_valid.
- Store formatting:
  - SB: be=4'b0001<<addr[1:0], wdata={4{data[7:0]}}.
  - SH: be=4'b0011<<{addr[1],1'b0}, wdata={2{data[15:0]}}.
  - SW: be=4'b1111, wdata=data.
  - Loads drive be=4'b1111 and wdata=0.
- BUSY:
  - Inputs are ignored; the request outputs are held stable.
  - o_stall = !i_mem_ack, so EX/MEM advances on the ack edge.
  - On i_mem_ack: next edge drops o_mem_req, returns to IDLE and sets o_wb_valid=1. For loads o_wb_en=latched wb_en and o_wb_data=extracted value; for stores o_wb_en=0 and o_wb_data=0.
  - Minimum memory-op latency: 2 cycles (ack in the first BUSY cycle).
- Load extraction from i_mem_rdata:
  - Byte lane = addr[1:0]; halfword lane = addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word unchanged.
- Timeout (ACK_TIMEOUT>0): the counter increments each BUSY cycle without ack.
  - When count reaches ACK_TIMEOUT-1 with no ack, o_stall is still 1 that cycle.
  - Next edge drops o_mem_req, pulses o_fault with the latched PC, produces no writeback and returns to IDLE.
  - An ack arriving in that same cycle wins over the timeout.
- A spurious i_mem_ack in IDLE is ignored.
- o_fault always returns to 0 one cycle after its pulse.

Test Plan:
- LB at addr 0x103, rdata=0x80FF_FF7F, ack one cycle after req -> be=1111, o_mem_addr=0x100, stall high 2 cycles, o_wb_data=0xFFFF_FF80, o_wb_en=1.
- SH at addr 0x202, data=0x1234_ABCD -> o_mem_be=1100, o_mem_wdata=0xABCD_ABCD, o_mem_we=1, retire with o_wb_en=0.
- LHU at 0x0, ack delayed 3 BUSY cycles, rdata=0x0000_8001 -> o_stall high 4 cycles, o_mem_req held stable, o_wb_data=0x0000_8001.
- LW at 0x102, PC=0x40 -> no o_mem_req, o_stall=0, o_fault 1-cycle pulse, o_fault_pc=0x40, o_wb_valid=0.
- ACK_TIMEOUT=4, load never acked -> req held 4 cycles then drops, o_fault pulse, state IDLE, following ALU op retires normally.
- Reset asserted in 2nd BUSY cycle -> o_mem_req=0 and all outputs 0 after that edge; late ack afterwards ignored, no writeback.
